// File: rtl/camera_frame_writer_if.sv
// camera_frame_writer_if: camera strobe/data inputs and frame-buffer write port of camera_frame_writer.
interface camera_frame_writer_if #(parameter int ADDR_W = 19, parameter int PIX_W = 8);
  logic              pixel_valid;
  logic [31:0]       data_in;
  logic [1:0]        chan_sel;
  logic              frame_done;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [PIX_W-1:0]  pixel_out;
  logic              frame_ready;
  logic              rd_buf;
  logic [7:0]        frame_count;
  logic              overflow;
  logic              short_frame;
  modport master (output pixel_valid, data_in, chan_sel, frame_done,
                  input addr, we, pixel_out, frame_ready, rd_buf, frame_count, overflow, short_frame);
  modport slave (input pixel_valid, data_in, chan_sel, frame_done,
                 output addr, we, pixel_out, frame_ready, rd_buf, frame_count, overflow, short_frame);
endinterface

// File: rtl/camera_frame_writer.sv
// camera_frame_writer: frame-synchronised, decimating camera-to-BRAM pixel writer.
// Define CAM_DOUBLE_BUFFER_EN for ping-pong frame buffers.
module camera_frame_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DECIM_LOG2 = 0,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 19
) (
  input logic clk,
  input logic reset,
  camera_frame_writer_if.slave bus
);
  localparam int FRAME_PIX = (H_ACTIVE >> DECIM_LOG2) * (V_ACTIVE >> DECIM_LOG2);
  localparam logic [ADDR_W:0] FP = (ADDR_W+1)'(FRAME_PIX);
  localparam logic [15:0] H_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] DMASK = 16'((1 << DECIM_LOG2) - 1);
  typedef enum logic [1:0] {SYNC, CAPTURE, HOLD} state_t;
  state_t state, state_n;
  logic [15:0] col, row;
  logic [ADDR_W:0] wcount;
  logic [ADDR_W-1:0] base;
  logic [7:0] sel_byte;
  logic keep, wr, ovf, fend;
`ifdef CAM_DOUBLE_BUFFER_EN
  logic wr_buf;
  assign base = wr_buf ? ADDR_W'(FRAME_PIX) : '0;
  always_ff @(posedge clk)
    if (reset) begin
      wr_buf <= 1'b0;
      bus.rd_buf <= 1'b0;
    end else if (fend) begin
      bus.rd_buf <= wr_buf;
      wr_buf <= ~wr_buf;
    end
`else
  assign base = '0;
  assign bus.rd_buf = 1'b0;
`endif
  always_comb begin
    keep = state == CAPTURE && bus.pixel_valid && (col & DMASK) == 16'd0 && (row & DMASK) == 16'd0;
    wr = keep && wcount < FP;
    ovf = keep && wcount >= FP;
    fend = bus.frame_done && state != SYNC;
    sel_byte = bus.data_in[{bus.chan_sel, 3'b000} +: 8];
    state_n = bus.frame_done ? CAPTURE : ovf ? HOLD : state;
  end
  always_ff @(posedge clk) state <= reset ? SYNC : state_n;
  always_ff @(posedge clk)
    if (reset) begin
      bus.addr <= '0;
      bus.we <= 1'b0;
      bus.pixel_out <= '0;
      bus.frame_ready <= 1'b0;
      bus.frame_count <= '0;
      bus.overflow <= 1'b0;
      bus.short_frame <= 1'b0;
      col <= '0;
      row <= '0;
      wcount <= '0;
    end else begin
      bus.we <= wr;
      bus.frame_ready <= fend;
      if (wr) begin
        bus.addr <= base + wcount[ADDR_W-1:0];
        bus.pixel_out <= sel_byte[7 -: PIX_W];
      end
      if (ovf) bus.overflow <= 1'b1;
      // a pixel coinciding with frame_done still counts toward the ending frame
      if (fend) begin
        bus.frame_count <= bus.frame_count + 8'd1;
        if (wcount + (ADDR_W+1)'(wr) < FP) bus.short_frame <= 1'b1;
      end
      if (bus.frame_done) begin
        col <= '0;
        row <= '0;
        wcount <= '0;
      end else if (state == CAPTURE && bus.pixel_valid) begin
        col <= col == H_LAST ? 16'd0 : col + 16'd1;
        if (col == H_LAST && row != V_LAST) row <= row + 16'd1;
        wcount <= wcount + (ADDR_W+1)'(wr);
      end
    end
endmodule
